// File: rtl/vld_txn_ctrl_gen.sv
// Splits a unit-stride vector load request into AXI4 INCR read bursts (MaxBurstLen / 4 KiB limited)
// with one transaction-control entry per burst. Optional VLD_TXN_PERF_CNT_EN adds perf_bursts_o.
module vld_txn_ctrl_gen #(
    parameter int AxiDataWidth = 128,
    parameter int AxiAddrWidth = 64,
    parameter int MaxBurstLen  = 16,
    parameter int ReqLenWidth  = 16,
    parameter int BeatCntW     = $clog2(MaxBurstLen) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [AxiAddrWidth-1:0]               req_addr_i,
    input  logic [ReqLenWidth-1:0]                req_bytes_i,
    output logic                                  ar_valid_o,
    input  logic                                  ar_ready_i,
    output logic [AxiAddrWidth-1:0]               ar_addr_o,
    output logic [7:0]                            ar_len_o,
    output logic [2:0]                            ar_size_o,
    output logic [1:0]                            ar_burst_o,
    output logic                                  txn_valid_o,
    input  logic                                  txn_ready_i,
    output logic [$clog2(AxiDataWidth/8)-1:0]     txn_first_off_o,
    output logic [$clog2(AxiDataWidth/8):0]       txn_last_bytes_o,
    output logic [BeatCntW-1:0]                   txn_beats_o,
    output logic                                  txn_last_o
`ifdef VLD_TXN_PERF_CNT_EN
    ,
    output logic [31:0]                           perf_bursts_o
`endif
);

    localparam int BusBytes = AxiDataWidth / 8;
    localparam int BusBSize = $clog2(BusBytes);
    localparam int LbW      = BusBSize + 1;
    localparam int CalcW    = (ReqLenWidth + 1 > 13) ? ReqLenWidth + 1 : 13;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    load_q, load_d;
    logic                    first_q;
    logic [AxiAddrWidth-1:0] cur_addr_q;
    logic [ReqLenWidth-1:0]  rem_q;

    logic [BusBSize-1:0]     off;
    logic [AxiAddrWidth-1:0] aligned;
    logic [CalcW-1:0]        rem_w, off_w, need, to4k, beats, avail, consumed, last_bytes;

    logic req_fire, req_nonzero, ar_done, txn_done, retire;

    assign ar_size_o  = 3'(BusBSize);
    assign ar_burst_o = 2'b01;

    // Burst geometry for the burst starting at cur_addr_q with rem_q bytes left.
    always_comb begin
        off        = first_q ? cur_addr_q[BusBSize-1:0] : '0;
        aligned    = {cur_addr_q[AxiAddrWidth-1:BusBSize], {BusBSize{1'b0}}};
        rem_w      = CalcW'(rem_q);
        off_w      = CalcW'(off);
        need       = (off_w + rem_w + CalcW'(BusBytes - 1)) >> BusBSize;
        to4k       = (CalcW'(4096) - CalcW'(aligned[11:0])) >> BusBSize;
        beats      = need;
        if (beats > CalcW'(MaxBurstLen)) beats = CalcW'(MaxBurstLen);
        if (beats > to4k) beats = to4k;
        avail      = (beats << BusBSize) - off_w;
        consumed   = (rem_w < avail) ? rem_w : avail;
        last_bytes = off_w + consumed - ((beats - CalcW'(1)) << BusBSize);
    end

    // A burst retires when each channel has either handshaken earlier or does so now.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        req_fire    = req_valid_i && req_ready_o;
        req_nonzero = (req_bytes_i != '0);
        ar_done     = !ar_valid_o || ar_ready_i;
        txn_done    = !txn_valid_o || txn_ready_i;
        retire      = (state_q == ISSUE) && !load_q && ar_done && txn_done;
        state_d     = state_q;
        load_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire && req_nonzero) begin
                    state_d = ISSUE;
                    load_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (retire) begin
                    if (txn_last_o) state_d = IDLE;
                    else            load_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            load_q           <= 1'b0;
            first_q          <= 1'b0;
            cur_addr_q       <= '0;
            rem_q            <= '0;
            ar_valid_o       <= 1'b0;
            txn_valid_o      <= 1'b0;
            ar_addr_o        <= '0;
            ar_len_o         <= '0;
            txn_first_off_o  <= '0;
            txn_last_bytes_o <= '0;
            txn_beats_o      <= '0;
            txn_last_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            if (req_fire && req_nonzero) begin
                cur_addr_q <= req_addr_i;
                rem_q      <= req_bytes_i;
                first_q    <= 1'b1;
            end else if (retire) begin
                cur_addr_q <= cur_addr_q + AxiAddrWidth'(consumed);
                rem_q      <= rem_q - ReqLenWidth'(consumed);
                first_q    <= 1'b0;
            end
            if (load_q) begin
                ar_valid_o       <= 1'b1;
                txn_valid_o      <= 1'b1;
                ar_addr_o        <= aligned;
                ar_len_o         <= 8'(beats - CalcW'(1));
                txn_first_off_o  <= off;
                txn_last_bytes_o <= LbW'(last_bytes);
                txn_beats_o      <= BeatCntW'(beats);
                txn_last_o       <= (rem_w == consumed);
            end else begin
                if (ar_valid_o && ar_ready_i)   ar_valid_o  <= 1'b0;
                if (txn_valid_o && txn_ready_i) txn_valid_o <= 1'b0;
            end
        end
    end

`ifdef VLD_TXN_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_bursts_o <= '0;
        end else if (retire && (perf_bursts_o != 32'hFFFF_FFFF)) begin
            perf_bursts_o <= perf_bursts_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vld_txn_ctrl_gen.sv
// Directed bench for vld_txn_ctrl_gen with AxiDataWidth=128, MaxBurstLen=16 and hand-computed bursts.
module tb_vld_txn_ctrl_gen;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_bytes;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_first_off;
    logic [4:0]  txn_last_bytes;
    logic [4:0]  txn_beats;
    logic        txn_last;

    int n_cmp = 0;
    int n_err = 0;
    int waited;

    vld_txn_ctrl_gen dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_bytes_i      (req_bytes),
        .ar_valid_o       (ar_valid),
        .ar_ready_i       (ar_ready),
        .ar_addr_o        (ar_addr),
        .ar_len_o         (ar_len),
        .ar_size_o        (ar_size),
        .ar_burst_o       (ar_burst),
        .txn_valid_o      (txn_valid),
        .txn_ready_i      (txn_ready),
        .txn_first_off_o  (txn_first_off),
        .txn_last_bytes_o (txn_last_bytes),
        .txn_beats_o      (txn_beats),
        .txn_last_o       (txn_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [63:0] addr, input logic [15:0] bytes);
        req_valid = 1'b1;
        req_addr  = addr;
        req_bytes = bytes;
        chk("req_ready_at_send", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ar(output int w);
        w = 0;
        while (!ar_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Waits for a burst, checks both channels, then accepts both in one cycle.
    task automatic expect_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                                input logic [3:0] off, input logic [4:0] beats,
                                input logic [4:0] lastb, input logic last, output int w);
        wait_ar(w);
        chk({tag, ".ar_valid"}, {63'd0, ar_valid}, 64'd1);
        chk({tag, ".txn_valid"}, {63'd0, txn_valid}, 64'd1);
        chk({tag, ".ar_addr"}, ar_addr, addr);
        chk({tag, ".ar_len"}, {56'd0, ar_len}, {56'd0, len});
        chk({tag, ".ar_size"}, {61'd0, ar_size}, 64'd4);
        chk({tag, ".ar_burst"}, {62'd0, ar_burst}, 64'd1);
        chk({tag, ".first_off"}, {60'd0, txn_first_off}, {60'd0, off});
        chk({tag, ".beats"}, {59'd0, txn_beats}, {59'd0, beats});
        chk({tag, ".last_bytes"}, {59'd0, txn_last_bytes}, {59'd0, lastb});
        chk({tag, ".last"}, {63'd0, txn_last}, {63'd0, last});
        ar_ready  = 1'b1;
        txn_ready = 1'b1;
        @(negedge clk);
        ar_ready  = 1'b0;
        txn_ready = 1'b0;
        chk({tag, ".ar_valid_drop"}, {63'd0, ar_valid}, 64'd0);
        chk({tag, ".txn_valid_drop"}, {63'd0, txn_valid}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_bytes = '0;
        ar_ready  = 1'b0;
        txn_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst.req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst.ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("rst.txn_valid", {63'd0, txn_valid}, 64'd0);
        chk("rst.ar_addr", ar_addr, 64'd0);
        chk("rst.ar_len", {56'd0, ar_len}, 64'd0);
        chk("rst.ar_size", {61'd0, ar_size}, 64'd4);
        chk("rst.ar_burst", {62'd0, ar_burst}, 64'd1);
        chk("rst.txn_fields", {49'd0, txn_first_off, txn_last_bytes, txn_beats, txn_last}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single aligned burst; valids appear one cycle after the request handshake.
        send_req(64'h1000, 16'd64);
        chk("c1.no_valid_yet", {63'd0, ar_valid}, 64'd0);
        chk("c1.req_ready_busy", {63'd0, req_ready}, 64'd0);
        expect_burst("c1", 64'h1000, 8'd3, 4'd0, 5'd4, 5'd16, 1'b1, waited);
        chk("c1.latency", waited, 64'd1);
        chk("c1.req_ready_after", {63'd0, req_ready}, 64'd1);

        // Unaligned start.
        send_req(64'h1004, 16'd20);
        expect_burst("c2", 64'h1000, 8'd1, 4'd4, 5'd2, 5'd8, 1'b1, waited);
        chk("c2.req_ready_after", {63'd0, req_ready}, 64'd1);

        // 4 KiB crossing.
        send_req(64'h0FF0, 16'd32);
        expect_burst("c3a", 64'h0FF0, 8'd0, 4'd0, 5'd1, 5'd16, 1'b0, waited);
        chk("c3a.req_ready_mid", {63'd0, req_ready}, 64'd0);
        expect_burst("c3b", 64'h1000, 8'd0, 4'd0, 5'd1, 5'd16, 1'b1, waited);
        chk("c3b.gap", waited, 64'd1);

        // MaxBurstLen split.
        send_req(64'h2000, 16'd300);
        expect_burst("c4a", 64'h2000, 8'd15, 4'd0, 5'd16, 5'd16, 1'b0, waited);
        expect_burst("c4b", 64'h2100, 8'd2, 4'd0, 5'd3, 5'd12, 1'b1, waited);
        chk("c4b.gap", waited, 64'd1);

        // AR backpressure with txn accepted immediately.
        send_req(64'h4FF0, 16'd48);
        wait_ar(waited);
        chk("bp.ar_valid", {63'd0, ar_valid}, 64'd1);
        txn_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.txn_valid_low", {63'd0, txn_valid}, 64'd0);
            chk("bp.ar_valid_held", {63'd0, ar_valid}, 64'd1);
            chk("bp.ar_addr_stable", ar_addr, 64'h4FF0);
            chk("bp.ar_len_stable", {56'd0, ar_len}, 64'd0);
        end
        txn_ready = 1'b0;
        ar_ready  = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        chk("bp.ar_valid_drop", {63'd0, ar_valid}, 64'd0);
        expect_burst("bp2", 64'h5000, 8'd1, 4'd0, 5'd2, 5'd16, 1'b1, waited);
        chk("bp2.gap", waited, 64'd1);

        // Zero-byte request is dropped.
        send_req(64'h6000, 16'd0);
        for (int i = 0; i < 4; i++) begin
            chk("zero.ar_valid", {63'd0, ar_valid}, 64'd0);
            chk("zero.txn_valid", {63'd0, txn_valid}, 64'd0);
            chk("zero.req_ready", {63'd0, req_ready}, 64'd1);
            @(negedge clk);
        end

        // Asynchronous reset during the second burst.
        send_req(64'h2000, 16'd300);
        expect_burst("rs_a", 64'h2000, 8'd15, 4'd0, 5'd16, 5'd16, 1'b0, waited);
        wait_ar(waited);
        chk("rs.second_ar_addr", ar_addr, 64'h2100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs.ar_valid_async", {63'd0, ar_valid}, 64'd0);
        chk("rs.txn_valid_async", {63'd0, txn_valid}, 64'd0);
        chk("rs.req_ready_async", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs.req_ready_after", {63'd0, req_ready}, 64'd1);
        chk("rs.ar_valid_after", {63'd0, ar_valid}, 64'd0);
        send_req(64'h3000, 16'd16);
        expect_burst("rs_new", 64'h3000, 8'd0, 4'd0, 5'd1, 5'd16, 1'b1, waited);
        chk("rs_new.req_ready", {63'd0, req_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
